// File: rtl/pam4_sched_pkg.sv
// pam4_sched_pkg
// Shared definitions for the PAM4 frame scheduler:
//   - sched_state_e : scheduler FSM states
//   - HDR_LEN_DEF   : default header length (generator cycles from enable-accept
//                     to the first PRBS symbol)
//   - CNT_W_DEF     : default width of the length/gap/frame counters
package pam4_sched_pkg;

    localparam int HDR_LEN_DEF = 6;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HEAD = 3'd2,
        PAY  = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } sched_state_e;

endpackage

// File: rtl/pam4_frame_sched_down_cnt.sv
// sched_down_cnt
// Loadable down-counter with a zero flag. The scheduler loads it with
// (phase length - 1) and decrements once per cycle of the phase; the phase
// ends on the cycle where zero is high. Load has priority over decrement.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle
//   load_val  : value to load (W bits)
//   dec       : decrement this cycle (holds at zero)
//   zero      : count is zero
module sched_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pam4_frame_sched.sv
// pam4_frame_sched
// Frame scheduler for the PAM4 symbol generator. Emits a sequence of frames
// (send_enable pulse, HDR_LEN header cycles, L payload cycles ending in
// send_stop) separated by a programmable idle gap, then pulses done.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (shared with generator)
//   start             : 1-cycle request, accepted only in IDLE (wins over abort)
//   abort             : terminate the sequence at the earliest legal point
//   cfg_payload_len   : PRBS symbols per frame (0 treated as 1)
//   cfg_gap_len       : idle cycles between frames
//   cfg_num_frames    : frames per sequence
//   send_enable       : frame start pulse to the generator
//   send_stop         : last payload symbol cycle (or abort stop)
//   in_payload        : generator is outputting PRBS symbols
//   busy              : scheduler not IDLE
//   done              : 1-cycle pulse at the end of a sequence
//   frame_cnt         : frames completed in the current sequence
// Configuration macro FRAME_SCHED_CONT_EN:
//   defined   : cfg_num_frames=0 runs frames until abort; frame_cnt wraps
//   undefined : cfg_num_frames=0 gives an immediate done; frame_cnt saturates
module pam4_frame_sched
    import pam4_sched_pkg::*;
#(
    parameter int HDR_LEN = HDR_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_payload_len,
    input  logic [CNT_W-1:0] cfg_gap_len,
    input  logic [CNT_W-1:0] cfg_num_frames,
    output logic             send_enable,
    output logic             send_stop,
    output logic             in_payload,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] HDR_LOAD = CNT_W'(HDR_LEN - 1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] frames_left_q, frames_left_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             abort_pend_q, abort_pend_d;
`ifdef FRAME_SCHED_CONT_EN
    logic             cont_q, cont_d;
`endif

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic [CNT_W-1:0] pay_load;
    logic [CNT_W-1:0] frame_cnt_inc;
    logic             last_frame;

    // One counter times HEAD, PAY and GAP; each phase loads it on the
    // cycle before it starts.
    sched_down_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // A zero payload length is stretched to one symbol.
    assign pay_load = (len_q == '0) ? '0 : (len_q - CNT_W'(1));

`ifdef FRAME_SCHED_CONT_EN
    assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);
    assign last_frame    = !cont_q && (frames_left_q == CNT_W'(1));
`else
    assign frame_cnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : (frame_cnt_q + CNT_W'(1));
    assign last_frame    = (frames_left_q == CNT_W'(1));
`endif

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        gap_d         = gap_q;
        frames_left_d = frames_left_q;
        frame_cnt_d   = frame_cnt_q;
        abort_pend_d  = abort_pend_q;
`ifdef FRAME_SCHED_CONT_EN
        cont_d        = cont_q;
`endif
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d         = cfg_payload_len;
                    gap_d         = cfg_gap_len;
                    frames_left_d = cfg_num_frames;
                    frame_cnt_d   = '0;
                    abort_pend_d  = 1'b0;
`ifdef FRAME_SCHED_CONT_EN
                    cont_d        = (cfg_num_frames == '0);
                    state_d       = ARM;
`else
                    state_d       = (cfg_num_frames == '0) ? DONE : ARM;
`endif
                end
            end
            ARM: begin
                cnt_load     = 1'b1;
                cnt_load_val = HDR_LOAD;
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                state_d = HEAD;
            end
            HEAD: begin
                // The generator ignores stop during its header, so an abort
                // here is remembered and served on the first payload cycle.
                cnt_dec = 1'b1;
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = pay_load;
                    state_d      = PAY;
                end
            end
            PAY: begin
                cnt_dec = 1'b1;
                if (abort || abort_pend_q) begin
                    state_d = DONE;
                end else if (cnt_zero) begin
                    frame_cnt_d = frame_cnt_inc;
                    if (last_frame) begin
                        state_d = DONE;
                    end else begin
`ifdef FRAME_SCHED_CONT_EN
                        if (!cont_q) begin
                            frames_left_d = frames_left_q - CNT_W'(1);
                        end
`else
                        frames_left_d = frames_left_q - CNT_W'(1);
`endif
                        if (gap_q == '0) begin
                            state_d = ARM;
                        end else begin
                            cnt_load     = 1'b1;
                            cnt_load_val = gap_q - CNT_W'(1);
                            state_d      = GAP;
                        end
                    end
                end
            end
            GAP: begin
                cnt_dec = 1'b1;
                if (abort) begin
                    state_d = DONE;
                end else if (cnt_zero) begin
                    state_d = ARM;
                end
            end
            DONE: begin
                abort_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            gap_q         <= '0;
            frames_left_q <= '0;
            frame_cnt_q   <= '0;
            abort_pend_q  <= 1'b0;
`ifdef FRAME_SCHED_CONT_EN
            cont_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            gap_q         <= gap_d;
            frames_left_q <= frames_left_d;
            frame_cnt_q   <= frame_cnt_d;
            abort_pend_q  <= abort_pend_d;
`ifdef FRAME_SCHED_CONT_EN
            cont_q        <= cont_d;
`endif
        end
    end

    // Outputs decode the state; send_stop also reacts to abort within the
    // same payload cycle.
    always_comb begin
        send_enable = (state_q == ARM);
        in_payload  = (state_q == PAY);
        send_stop   = (state_q == PAY) && (cnt_zero || abort || abort_pend_q);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pam4_frame_sched.sv
// tb_pam4_frame_sched
// Scoreboard bench for pam4_frame_sched. Each test pushes the expected
// handshake events (enable / stop with payload count / done with frame_cnt)
// at absolute cycle numbers; a monitor pops and compares on every event.
module tb_pam4_frame_sched;

    localparam int CW = 16;
    localparam int H  = 6;

    localparam int EV_EN   = 0;
    localparam int EV_STOP = 1;
    localparam int EV_DONE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_payload_len;
    logic [CW-1:0] cfg_gap_len;
    logic [CW-1:0] cfg_num_frames;
    logic          send_enable;
    logic          send_stop;
    logic          in_payload;
    logic          busy;
    logic          done;
    logic [CW-1:0] frame_cnt;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } exp_t;

    exp_t expq[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   pay_count = 0;

    pam4_frame_sched #(
        .HDR_LEN (H),
        .CNT_W   (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_payload_len (cfg_payload_len),
        .cfg_gap_len     (cfg_gap_len),
        .cfg_num_frames  (cfg_num_frames),
        .send_enable     (send_enable),
        .send_stop       (send_stop),
        .in_payload      (in_payload),
        .busy            (busy),
        .done            (done),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input int kind, input int c, input int v);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic handleEvent(input int kind, input int val);
        exp_t e;
        if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d expected no event", kind, cyc);
        end else begin
            e = expq.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_cycle", cyc, e.cyc);
            checkOutput("event_value", val, e.val);
        end
    endtask

    // Monitor: samples just after the falling edge so combinational abort
    // effects on send_stop are settled.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (send_enable) pay_count = 0;
            if (in_payload)  pay_count++;
            if (send_enable) handleEvent(EV_EN, 0);
            if (send_stop)   handleEvent(EV_STOP, pay_count);
            if (done)        handleEvent(EV_DONE, int'(frame_cnt));
        end
    end

    // Called at a falling edge; start is high for cycle s, ARM follows in s+1.
    task automatic applyStimulus(input int len, input int gap, input int frames,
                                 input logic with_abort, output int s);
        cfg_payload_len = CW'(len);
        cfg_gap_len     = CW'(gap);
        cfg_num_frames  = CW'(frames);
        start           = 1'b1;
        abort           = with_abort;
        s               = cyc;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulseAbort(input int at_cycle);
        waitUntil(at_cycle);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) checkOutput({name, "_done_timeout"}, 0, 1);
        @(negedge clk);
        #2;
        checkOutput({name, "_queue_drained"}, expq.size(), 0);
        checkOutput({name, "_idle_after_done"}, int'(busy), 0);
        expq.delete();
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_send_enable"}, int'(send_enable), 0);
        checkOutput({name, "_send_stop"},   int'(send_stop), 0);
        checkOutput({name, "_in_payload"},  int'(in_payload), 0);
        checkOutput({name, "_busy"},        int'(busy), 0);
        checkOutput({name, "_done"},        int'(done), 0);
        checkOutput({name, "_frame_cnt"},   int'(frame_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got still running expected finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int s;
        int s2;
        rst             = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        cfg_payload_len = '0;
        cfg_gap_len     = '0;
        cfg_num_frames  = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: len=8 gap=3 frames=2
        $display("[TB] test 1: two frames len 8 gap 3");
        applyStimulus(8, 3, 2, 1'b0, s);
        pushExp(EV_EN,   s + 1,  0);
        pushExp(EV_STOP, s + 1 + H + 8, 8);
        pushExp(EV_EN,   s + 1 + H + 8 + 1 + 3, 0);
        pushExp(EV_STOP, s + 1 + 2 * (H + 8) + 1 + 3, 8);
        pushExp(EV_DONE, s + 1 + 2 * (H + 8) + 1 + 3 + 1, 2);
        waitDone("t1", 100);

        // 2: len=0 gap=0 frames=3, abort together with start is ignored
        $display("[TB] test 2: zero length, zero gap, three frames");
        applyStimulus(0, 0, 3, 1'b1, s);
        for (int f = 0; f < 3; f++) begin
            pushExp(EV_EN,   s + 1 + f * (H + 2), 0);
            pushExp(EV_STOP, s + 1 + f * (H + 2) + H + 1, 1);
        end
        pushExp(EV_DONE, s + 1 + 2 * (H + 2) + H + 2, 3);
        waitDone("t2", 100);

        // 3: abort during HEAD of frame 1
        $display("[TB] test 3: abort in header");
        applyStimulus(20, 2, 2, 1'b0, s);
        pushExp(EV_EN,   s + 1, 0);
        pushExp(EV_STOP, s + 1 + H + 1, 1);
        pushExp(EV_DONE, s + 1 + H + 2, 0);
        pulseAbort(s + 3);
        waitDone("t3", 100);

        // 4: abort in PAY cycle 5 of frame 2
        $display("[TB] test 4: abort in payload of frame 2");
        applyStimulus(10, 2, 3, 1'b0, s);
        pushExp(EV_EN,   s + 1, 0);
        pushExp(EV_STOP, s + 1 + H + 10, 10);
        pushExp(EV_EN,   s + 1 + H + 10 + 1 + 2, 0);
        pushExp(EV_STOP, s + 20 + H + 5, 5);
        pushExp(EV_DONE, s + 20 + H + 6, 1);
        pulseAbort(s + 20 + H + 5);
        waitDone("t4", 100);

`ifdef FRAME_SCHED_CONT_EN
        // 5: continuous mode, abort in the gap after three frames
        $display("[TB] test 5: continuous frames until abort");
        applyStimulus(1, 1, 0, 1'b0, s);
        for (int f = 0; f < 3; f++) begin
            pushExp(EV_EN,   s + 1 + f * (H + 3), 0);
            pushExp(EV_STOP, s + 1 + f * (H + 3) + H + 1, 1);
        end
        pushExp(EV_DONE, s + 1 + 2 * (H + 3) + H + 3, 3);
        pulseAbort(s + 1 + 2 * (H + 3) + H + 2);
        waitDone("t5", 100);
`else
        // 5: frames=0 gives an immediate done, no enable
        $display("[TB] test 5: zero frames");
        applyStimulus(8, 3, 0, 1'b0, s);
        pushExp(EV_DONE, s + 1, 0);
        waitDone("t5", 20);
`endif

        // 6: reset mid-PAY, then a clean run with cfg churn while busy
        $display("[TB] test 6: reset in payload then restart");
        applyStimulus(8, 3, 2, 1'b0, s);
        pushExp(EV_EN, s + 1, 0);
        waitUntil(s + 1 + H + 3);
        rst = 1'b1;
        @(negedge clk);
        #2;
        checkAllZero("t6_reset");
        checkOutput("t6_queue_after_reset", expq.size(), 0);
        expq.delete();
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(2, 1, 1, 1'b0, s2);
        cfg_payload_len = CW'(50);
        cfg_gap_len     = CW'(7);
        cfg_num_frames  = CW'(5);
        pushExp(EV_EN,   s2 + 1, 0);
        pushExp(EV_STOP, s2 + 1 + H + 2, 2);
        pushExp(EV_DONE, s2 + 1 + H + 3, 1);
        waitDone("t6", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
